// File: rtl/i2s_mic_model.sv
// i2s_mic_model
// System-clocked I2S (Philips) microphone model. It oversamples the master's
// SCK/WS, loads a per-channel sample at each slot start, and shifts the sample
// out MSB first on SDO. SDO changes one SCK after the WS edge and is
// zero-filled past SAMPLE_W. Every loaded sample is reported on smp_*.
// A slot that ends before all bits were sent raises trunc.
module i2s_mic_model #(
   parameter int          SAMPLE_W  = 18,
   parameter int          MODE      = 0,
   parameter logic [31:0] LEFT_VAL  = 32'h0001_0A0B,
   parameter logic [31:0] RIGHT_VAL = 32'h0002_0D0F
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sck,
   input  logic                ws,
   input  logic [1:0]          chan_en,
   output logic                sdo,
   output logic                sdo_oe,
   output logic                smp_valid,
   output logic [SAMPLE_W-1:0] smp_data,
   output logic                smp_ch,
   output logic                trunc
);

   // Mask that keeps the low SAMPLE_W bits (used by the counter mode)
   localparam logic [31:0] SMP_MASK   = (SAMPLE_W >= 32) ? 32'hFFFF_FFFF
                                        : ((32'd1 << SAMPLE_W) - 32'd1);
   localparam logic [5:0]  SAMPLE_W_C = 6'(SAMPLE_W);
   localparam logic [1:0]  MODE_SEL   = 2'(MODE);
   localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

   // Next value of a channel generator after one sample has been taken
   function automatic logic [31:0] gen_advance(input logic [31:0] g);
      logic [31:0] n;
      case (MODE_SEL)
         2'd1:    n = (g + 32'd1) & SMP_MASK;
         2'd2:    n = (g >> 1) ^ (g[0] ? LFSR_TAPS : 32'd0);
         default: n = g;
      endcase
      return n;
   endfunction

   // Synchroniser and edge-detect state
   logic                sck_meta_r;
   logic                sck_sync_r;
   logic                sck_prev_r;
   logic                ws_meta_r;
   logic                ws_sync_r;
   logic                sck_rise_s;
   logic                sck_fall_s;

   // Slot state
   logic                ws_last_r;
   logic                started_r;
   logic [5:0]          bit_cnt_r;
   logic [SAMPLE_W-1:0] shreg_r;
   logic [31:0]         gen_left_r;
   logic [31:0]         gen_right_r;
   logic [SAMPLE_W-1:0] load_val_s;
   logic                slot_start_s;
   logic                ch_en_s;
   logic                bit_left_s;

   // Two-flop synchronisers for sck/ws plus the sck edge register.
   // The sck registers reset high so a release with sck high creates no edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_meta_r <= 1'b1;
         sck_sync_r <= 1'b1;
         sck_prev_r <= 1'b1;
         ws_meta_r  <= 1'b1;
         ws_sync_r  <= 1'b1;
      end else begin
         sck_meta_r <= sck;
         sck_sync_r <= sck_meta_r;
         sck_prev_r <= sck_sync_r;
         ws_meta_r  <= ws;
         ws_sync_r  <= ws_meta_r;
      end
   end

   // Single-clock edge strobes and slot-start decode
   always_comb begin
      sck_rise_s   = sck_sync_r & ~sck_prev_r;
      sck_fall_s   = ~sck_sync_r & sck_prev_r;
      slot_start_s = sck_rise_s & (ws_sync_r != ws_last_r);
      ch_en_s      = chan_en[ws_sync_r];
      bit_left_s   = (bit_cnt_r < SAMPLE_W_C);
   end

   // Select the sample to load for the channel that is starting
   always_comb begin
      load_val_s = '0;
      if (ws_sync_r) begin
         load_val_s = gen_right_r[SAMPLE_W-1:0];
      end else begin
         load_val_s = gen_left_r[SAMPLE_W-1:0];
      end
   end

   // Channel generators: advance only when their channel sends a sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gen_left_r  <= LEFT_VAL;
         gen_right_r <= RIGHT_VAL;
      end else if (slot_start_s && ch_en_s) begin
         if (ws_sync_r) begin
            gen_right_r <= gen_advance(gen_right_r);
         end else begin
            gen_left_r  <= gen_advance(gen_left_r);
         end
      end else begin
         gen_left_r  <= gen_left_r;
         gen_right_r <= gen_right_r;
      end
   end

   // Slot start, serial shifting and the sample/truncation reports
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sdo       <= 1'b0;
         sdo_oe    <= 1'b0;
         smp_valid <= 1'b0;
         smp_data  <= '0;
         smp_ch    <= 1'b0;
         trunc     <= 1'b0;
         ws_last_r <= 1'b1;
         started_r <= 1'b0;
         bit_cnt_r <= 6'd0;
         shreg_r   <= '0;
      end else begin
         smp_valid <= 1'b0;
         trunc     <= 1'b0;
         if (slot_start_s) begin
            // The previous slot is judged before its state is overwritten
            trunc     <= started_r & sdo_oe & bit_left_s;
            ws_last_r <= ws_sync_r;
            started_r <= 1'b1;
            bit_cnt_r <= 6'd0;
            shreg_r   <= load_val_s;
            sdo_oe    <= ch_en_s;
            if (ch_en_s) begin
               smp_valid <= 1'b1;
               smp_data  <= load_val_s;
               smp_ch    <= ws_sync_r;
            end else begin
               smp_valid <= 1'b0;
            end
         end else if (sck_fall_s) begin
            if (started_r && sdo_oe && bit_left_s) begin
               sdo       <= shreg_r[SAMPLE_W-1];
               shreg_r   <= shreg_r << 1;
               bit_cnt_r <= bit_cnt_r + 6'd1;
            end else begin
               // Past the last bit, or in a disabled slot, the line stays low
               sdo <= 1'b0;
            end
         end else begin
            sdo <= sdo;
         end
      end
   end

endmodule

// File: tb/tb_i2s_mic_model.sv
// Directed bench for i2s_mic_model: three instances (fixed, counter, LFSR)
// share one I2S master. A receiver samples SDO just before each SCK rise.
module tb_i2s_mic_model;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sck = 1'b1;
   logic ws  = 1'b1;
   logic [1:0] chan_en = 2'b11;

   logic sdo0, oe0, v0, ch0, t0;
   logic sdo1, oe1, v1, ch1, t1;
   logic sdo2, oe2, v2, ch2, t2;
   logic [17:0] d0, d1, d2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   i2s_mic_model #(.SAMPLE_W(18), .MODE(0)) u0 (
      .clk(clk), .rst(rst), .sck(sck), .ws(ws), .chan_en(chan_en),
      .sdo(sdo0), .sdo_oe(oe0), .smp_valid(v0), .smp_data(d0), .smp_ch(ch0), .trunc(t0));
   i2s_mic_model #(.SAMPLE_W(18), .MODE(1)) u1 (
      .clk(clk), .rst(rst), .sck(sck), .ws(ws), .chan_en(chan_en),
      .sdo(sdo1), .sdo_oe(oe1), .smp_valid(v1), .smp_data(d1), .smp_ch(ch1), .trunc(t1));
   i2s_mic_model #(.SAMPLE_W(18), .MODE(2), .LEFT_VAL(32'h0000_0001)) u2 (
      .clk(clk), .rst(rst), .sck(sck), .ws(ws), .chan_en(chan_en),
      .sdo(sdo2), .sdo_oe(oe2), .smp_valid(v2), .smp_data(d2), .smp_ch(ch2), .trunc(t2));

   // Report log: every smp_valid / trunc pulse, sampled away from the active edge
   logic [18:0] q0[$];
   logic [18:0] q1[$];
   logic [18:0] q2[$];
   int tr0 = 0;
   int tv0 = 0;
   int tr1 = 0;
   always @(negedge clk) begin
      if (v0) q0.push_back({ch0, d0});
      if (v1) q1.push_back({ch1, d1});
      if (v2) q2.push_back({ch2, d2});
      if (t0) tr0++;
      if (t0 && v0) tv0++;
      if (t1) tr1++;
   end

   // Receiver captures of the last slot
   logic [63:0] rx0, rx1, rx2;
   logic first0, first1, first2;
   logic oe_s0, oe_s1, oe_s2;
   logic tm_a, tm_b;
   logic pre_oe, rst_sdo, rst_oe;
   int rd0, rd1, rd2;

   // One slot of n SCK periods (16 clk each); WS changes with the first fall
   task automatic run_slot(input logic ch, input int n, input int rst_k, input int rel_k);
      rx0 = '0; rx1 = '0; rx2 = '0;
      for (int k = 0; k < n; k++) begin
         sck = 1'b0;
         if (k == 0) ws = ch;
         if (k == rel_k) rst = 1'b0;
         @(negedge clk); @(negedge clk);
         if (k == 2) tm_a = sdo0;
         @(negedge clk);
         if (k == 2) tm_b = sdo0;
         if (k == rst_k) begin
            pre_oe = oe0;
            rst = 1'b1;
            #1;
            rst_sdo = sdo0 | sdo1 | sdo2;
            rst_oe  = oe0 | oe1 | oe2;
         end
         repeat (5) @(negedge clk);
         if (k == 0) begin
            first0 = sdo0; first1 = sdo1; first2 = sdo2;
         end else begin
            rx0[k] = sdo0; rx1[k] = sdo1; rx2[k] = sdo2;
         end
         if (k == 1) begin
            oe_s0 = oe0; oe_s1 = oe1; oe_s2 = oe2;
         end
         sck = 1'b1;
         repeat (8) @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Assemble an 18-bit sample from receiver bits 1..18
   function automatic logic [17:0] get_smp(input logic [63:0] rx);
      logic [17:0] s;
      for (int i = 0; i < 18; i++) s[17-i] = rx[i+1];
      return s;
   endfunction

   // First 16 received bits: 15 in-slot bits plus the bit seen at the next slot's first rise
   function automatic logic [15:0] top16(input logic [63:0] rx, input logic last);
      logic [15:0] r;
      for (int i = 1; i < 16; i++) r[16-i] = rx[i];
      r[0] = last;
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (sdo0 !== 1'b0) begin n_bad++; $display("FAIL reset_sdo got %b exp 0", sdo0); end
      n_cmp++; if (oe0 !== 1'b0) begin n_bad++; $display("FAIL reset_oe got %b exp 0", oe0); end
      n_cmp++; if ({v0, ch0, t0} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b exp 000", {v0, ch0, t0}); end
      n_cmp++; if (d0 !== 18'h0) begin n_bad++; $display("FAIL reset_data got %h exp 0", d0); end
   endtask

   task automatic test_idle();
      do_reset();
      rd0 = q0.size();
      run_slot(1'b1, 32, -1, -1);
      n_cmp++; if (rx0 !== 64'h0) begin n_bad++; $display("FAIL idle_sdo got %h exp 0", rx0); end
      n_cmp++; if (oe_s0 !== 1'b0) begin n_bad++; $display("FAIL idle_oe got %b exp 0", oe_s0); end
      n_cmp++; if (q0.size() != rd0) begin n_bad++; $display("FAIL idle_valid got %0d exp %0d", q0.size(), rd0); end
   endtask

   task automatic test_fixed();
      int tb;
      do_reset();
      chan_en = 2'b11;
      rd0 = q0.size();
      tb = tr0;
      for (int f = 0; f < 2; f++) begin
         run_slot(1'b0, 32, -1, -1);
         n_cmp++; if (get_smp(rx0) !== 18'h10A0B) begin n_bad++; $display("FAIL fixed_left got %h exp 10a0b", get_smp(rx0)); end
         n_cmp++; if (rx0[31:19] !== 13'h0) begin n_bad++; $display("FAIL fixed_zero_fill got %h exp 0", rx0[31:19]); end
         n_cmp++; if (oe_s0 !== 1'b1) begin n_bad++; $display("FAIL fixed_oe got %b exp 1", oe_s0); end
         if (f == 0) begin
            n_cmp++; if ({tm_a, tm_b} !== 2'b01) begin n_bad++; $display("FAIL sdo_latency got %b exp 01", {tm_a, tm_b}); end
         end
         n_cmp++;
         if (rd0 >= q0.size()) begin n_bad++; $display("FAIL fixed_valid_left got none exp 0_10a0b"); end
         else begin
            if (q0[rd0] !== {1'b0, 18'h10A0B}) begin n_bad++; $display("FAIL fixed_valid_left got %h exp 010a0b", q0[rd0]); end
            rd0++;
         end
         run_slot(1'b1, 32, -1, -1);
         n_cmp++; if (get_smp(rx0) !== 18'h20D0F) begin n_bad++; $display("FAIL fixed_right got %h exp 20d0f", get_smp(rx0)); end
         n_cmp++; if (first0 !== 1'b0) begin n_bad++; $display("FAIL fixed_bit32 got %b exp 0", first0); end
         n_cmp++;
         if (rd0 >= q0.size()) begin n_bad++; $display("FAIL fixed_valid_right got none exp 1_20d0f"); end
         else begin
            if (q0[rd0] !== {1'b1, 18'h20D0F}) begin n_bad++; $display("FAIL fixed_valid_right got %h exp 120d0f", q0[rd0]); end
            rd0++;
         end
      end
      n_cmp++; if (tr0 != tb) begin n_bad++; $display("FAIL fixed_no_trunc got %0d exp 0", tr0 - tb); end
   endtask

   task automatic test_counter();
      do_reset();
      rd1 = q1.size();
      for (int f = 0; f < 4; f++) begin
         run_slot(1'b0, 32, -1, -1);
         n_cmp++; if (get_smp(rx1) !== 18'(18'h10A0B + f)) begin n_bad++; $display("FAIL counter_left%0d got %h exp %h", f, get_smp(rx1), 18'(18'h10A0B + f)); end
         run_slot(1'b1, 32, -1, -1);
         n_cmp++; if (get_smp(rx1) !== 18'(18'h20D0F + f)) begin n_bad++; $display("FAIL counter_right%0d got %h exp %h", f, get_smp(rx1), 18'(18'h20D0F + f)); end
      end
      n_cmp++; if (q1.size() != rd1 + 8) begin n_bad++; $display("FAIL counter_valids got %0d exp 8", q1.size() - rd1); end
      else if (q1[rd1 + 7] !== {1'b1, 18'h20D12}) begin n_bad++; $display("FAIL counter_last_report got %h exp 120d12", q1[rd1 + 7]); end
   endtask

   task automatic test_lfsr();
      logic [17:0] exp_l[3];
      exp_l[0] = 18'h00001; exp_l[1] = 18'h00003; exp_l[2] = 18'h00002;
      do_reset();
      for (int f = 0; f < 3; f++) begin
         run_slot(1'b0, 32, -1, -1);
         n_cmp++; if (get_smp(rx2) !== exp_l[f]) begin n_bad++; $display("FAIL lfsr_left%0d got %h exp %h", f, get_smp(rx2), exp_l[f]); end
         run_slot(1'b1, 32, -1, -1);
         if (f == 0) begin
            n_cmp++; if (get_smp(rx2) !== 18'h20D0F) begin n_bad++; $display("FAIL lfsr_right_seed got %h exp 20d0f", get_smp(rx2)); end
         end
      end
   endtask

   task automatic test_chan_disable();
      do_reset();
      chan_en = 2'b01;
      rd1 = q1.size();
      for (int f = 0; f < 3; f++) begin
         run_slot(1'b0, 32, -1, -1);
         n_cmp++; if (get_smp(rx1) !== 18'(18'h10A0B + f)) begin n_bad++; $display("FAIL dis_left%0d got %h exp %h", f, get_smp(rx1), 18'(18'h10A0B + f)); end
         run_slot(1'b1, 32, -1, -1);
         n_cmp++; if ({oe_s1, rx1} !== 65'h0) begin n_bad++; $display("FAIL dis_right%0d got oe=%b sdo=%h exp 0", f, oe_s1, rx1); end
         n_cmp++; if (q1.size() != rd1 + f + 1) begin n_bad++; $display("FAIL dis_valids%0d got %0d exp %0d", f, q1.size() - rd1, f + 1); end
      end
      chan_en = 2'b11;
   endtask

   task automatic test_trunc();
      int tb, vb;
      logic [63:0] left_rx;
      do_reset();
      tb = tr0;
      vb = tv0;
      run_slot(1'b0, 16, -1, -1);
      left_rx = rx0;
      n_cmp++; if (tr0 != tb) begin n_bad++; $display("FAIL trunc_first got %0d exp 0", tr0 - tb); end
      run_slot(1'b1, 16, -1, -1);
      n_cmp++; if (top16(left_rx, first0) !== 16'h4282) begin n_bad++; $display("FAIL trunc_left_msbs got %h exp 4282", top16(left_rx, first0)); end
      left_rx = rx0;
      run_slot(1'b0, 16, -1, -1);
      n_cmp++; if (top16(left_rx, first0) !== 16'h8343) begin n_bad++; $display("FAIL trunc_right_msbs got %h exp 8343", top16(left_rx, first0)); end
      run_slot(1'b1, 16, -1, -1);
      run_slot(1'b0, 32, -1, -1);
      run_slot(1'b1, 32, -1, -1);
      n_cmp++; if (tr0 - tb != 4) begin n_bad++; $display("FAIL trunc_count got %0d exp 4", tr0 - tb); end
      n_cmp++; if (tv0 - vb != 4) begin n_bad++; $display("FAIL trunc_with_valid got %0d exp 4", tv0 - vb); end
   endtask

   task automatic test_reset_midslot();
      int tb;
      do_reset();
      run_slot(1'b0, 32, 5, -1);
      n_cmp++; if (pre_oe !== 1'b1) begin n_bad++; $display("FAIL mid_pre_oe got %b exp 1", pre_oe); end
      n_cmp++; if ({rst_sdo, rst_oe} !== 2'b00) begin n_bad++; $display("FAIL mid_async got sdo=%b oe=%b exp 0 0", rst_sdo, rst_oe); end
      run_slot(1'b1, 32, -1, 10);
      tb = tr1;
      rd1 = q1.size();
      run_slot(1'b0, 32, -1, -1);
      n_cmp++; if (get_smp(rx1) !== 18'h10A0B) begin n_bad++; $display("FAIL mid_left_seed got %h exp 10a0b", get_smp(rx1)); end
      run_slot(1'b1, 32, -1, -1);
      n_cmp++; if (get_smp(rx1) !== 18'h20D0F) begin n_bad++; $display("FAIL mid_right_seed got %h exp 20d0f", get_smp(rx1)); end
      n_cmp++; if (tr1 != tb) begin n_bad++; $display("FAIL mid_no_trunc got %0d exp 0", tr1 - tb); end
      n_cmp++;
      if (rd1 >= q1.size()) begin n_bad++; $display("FAIL mid_report got none exp 010a0b"); end
      else if (q1[rd1] !== {1'b0, 18'h10A0B}) begin n_bad++; $display("FAIL mid_report got %h exp 010a0b", q1[rd1]); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_fixed();
      test_counter();
      test_lfsr();
      test_chan_disable();
      test_trunc();
      test_reset_midslot();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
